aibcr3_dll_gry2thm_slew: RTL
============================

# aibcr3_dll_gry2thm_slew

Registered, parametrised gray-to-thermometer delay-code decoder for the DLL delay-line control path. It accepts gray-coded delay targets through a valid/ready handshake and converts each one to binary. It then walks the registered thermometer output toward the target a bounded number of taps per clock, so the delay line never sees a multi-tap glitch. It sits between the DLL phase-detector/loop-filter code and the delay-line tap enables, in the position previously held by the combinational 7-bit to 64-tap decoder.

## Interface
- GRY_W, 7, gray input width (2..10)
- THM_W, 64, thermometer output width, i.e. number of taps (1..2**GRY_W)
- STEP, 1, maximum taps changed per clock during slew (1..THM_W)
- CODE_W, $clog2(THM_W+1), derived localparam, not overridable

Ports:
- CLKIN  in  1  clock
- RSTb  in  1  reset, asynchronous assert, active-low; release synchronous to CLKIN upstream
- iSE  in  1  freeze; when high, all state holds and no input is accepted
- grey_vld  in  1  target valid
- grey  in  GRY_W  binary-reflected gray target
- grey_rdy  out  1  ready to accept target
- bk  out  THM_W  registered thermometer; bk[i]=1 for i < code
- code  out  CODE_W  current tap count, registered
- busy  out  1  slew in progress
- ovr  out  1  last accepted target exceeded THM_W and was clamped

## Operation
- Gray to binary: bin[i] = XOR of grey[GRY_W-1:i]. Target tgt = min(bin, THM_W), CODE_W bits.
- Accept: grey_vld & grey_rdy at a rising edge. On accept, load tgt and set ovr = (bin > THM_W). ovr holds until the next accept.
- grey_rdy = (state==IDLE) & ~iSE. This is combinational from the state register and iSE, with no dependency on grey_vld.
- States:
  - IDLE: code==tgt. On accept with tgt != code, go to SLEW. On accept with tgt == code, stay in IDLE; only ovr updates.
  - SLEW: each unfrozen edge, if |tgt-code| <= STEP, then code=tgt and go to IDLE. Otherwise code moves STEP toward tgt.
- busy = (state==SLEW).
- bk is registered with code (same edge). It is always a valid thermometer pattern, and per edge it changes by at most STEP bits, all on the same side.
- iSE high: code, bk, state, tgt and ovr hold; grey_rdy=0; grey_vld is ignored. Slew resumes on the first edge with iSE low.
- grey_vld during SLEW: ignored (grey_rdy=0). Upstream must hold it.
- Reset values (async, while RSTb low): code=0, bk=0, tgt=0, state=IDLE, busy=0, ovr=0. grey_rdy=~iSE.
- Reset mid-slew: all outputs go to their reset values immediately. No partial step is kept.

## Timing
- Accept edge E0 loads tgt. The first tap change occurs at E1.
- With a distance of d taps, code reaches tgt at edge E(ceil(d/STEP)), and state returns to IDLE on that same edge.
- grey_rdy is high in the cycle after the final step. The earliest next accept is the edge after that.
- An accept with tgt==code gives grey_rdy=1 in the following cycle, so back-to-back accepts are allowed.
- Edges where iSE is high add one cycle each to the latency.
- All outputs except grey_rdy come directly from flops.

## Configuration
- AIBCR3_DLL_GRY2THM_SLEW_EN
  - Defined: step-limited slew as described above.
  - Undefined: STEP is ignored, and SLEW always lasts exactly one edge. At E1, code=tgt and bk jumps to the full pattern. Handshake, freeze, ovr and reset behaviour are unchanged.

## Test plan
- Reset: RSTb low at E3 of a 0→5 slew. Required: code=0, bk=0, busy=0 asynchronously; grey_rdy=1 with iSE low.
- Default params, from code 0, accept grey=7'b0000111 (bin 5). Required: code=1,2,3,4,5 at E1..E5; bk=64'h1F at E5; busy low after E5; grey_rdy=1 in the next cycle.
- Accept grey=7'b1000000 (bin 127). Required: ovr=1; code clamps to 64 after 64 edges; bk all ones. Then accept bin 64. Required: ovr=0 and no busy.
- STEP=4, from code 64, accept grey=7'b0000011 (bin 2). Required: code 60,56,…,4,2, reaching 2 after 16 edges; never more than 4 bk bits change per edge.
- Freeze: iSE high for 3 cycles mid-slew, with grey_vld pulsing. Required: code and bk frozen, grey_rdy=0, target unchanged; slew completes 3 cycles late.
- Macro undefined, from 0, accept bin 40. Required: code=40 and bk=40 ones at E1; busy high for exactly one cycle.

Source files
------------

// File: rtl/aibcr3_dll_gry2thm_slew.sv
// Registered gray-to-thermometer DLL delay-code decoder with bounded per-clock slew.
// Define AIBCR3_DLL_GRY2THM_SLEW_EN for STEP-limited slew; otherwise each target lands in one edge.
module aibcr3_dll_gry2thm_slew #(
  parameter  int GRY_W  = 7,
  parameter  int THM_W  = 64,
  parameter  int STEP   = 1,
  localparam int CODE_W = $clog2(THM_W + 1)
) (
  input  logic              CLKIN,
  input  logic              RSTb,
  input  logic              iSE,
  input  logic              grey_vld,
  input  logic [GRY_W-1:0]  grey,
  output logic              grey_rdy,
  output logic [THM_W-1:0]  bk,
  output logic [CODE_W-1:0] code,
  output logic              busy,
  output logic              ovr
);

  if (GRY_W < 2 || GRY_W > 10 || THM_W < 1 || THM_W > (1 << GRY_W) ||
      STEP < 1 || STEP > THM_W) begin : g_param_check
    $error("aibcr3_dll_gry2thm_slew: parameter out of range");
  end

  typedef enum logic {IDLE, SLEW} state_e;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] tgt_q, tgt_d;
  logic [THM_W-1:0]  bk_q, bk_d;
  logic              ovr_q, ovr_d;

  logic [GRY_W-1:0]  bin;
  logic              bin_ovr;
  logic [CODE_W-1:0] tgt_in;
  logic [CODE_W-1:0] code_next;
  logic              accept;

  always_comb begin
    for (int i = 0; i < GRY_W; i++) begin
      bin[i] = ^(grey >> i);
    end
  end

  assign bin_ovr = 32'(bin) > 32'(THM_W);
  assign tgt_in  = bin_ovr ? CODE_W'(THM_W) : CODE_W'(bin);

`ifdef AIBCR3_DLL_GRY2THM_SLEW_EN
  localparam logic [CODE_W-1:0] STEP_C = CODE_W'(STEP);
  logic [CODE_W-1:0] dist;

  // Distance is computed unsigned on both sides so the final partial step lands exactly on tgt.
  always_comb begin
    dist      = (tgt_q > code_q) ? (tgt_q - code_q) : (code_q - tgt_q);
    code_next = tgt_q;
    if (dist > STEP_C) begin
      code_next = (tgt_q > code_q) ? (code_q + STEP_C) : (code_q - STEP_C);
    end
  end
`else
  assign code_next = tgt_q;
`endif

  assign grey_rdy = (state_q == IDLE) & ~iSE;
  assign accept   = grey_vld & grey_rdy;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tgt_d   = tgt_q;
    ovr_d   = ovr_q;
    if (!iSE) begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            tgt_d = tgt_in;
            ovr_d = bin_ovr;
            if (tgt_in != code_q) state_d = SLEW;
          end
        end
        SLEW: begin
          code_d = code_next;
          if (code_next == tgt_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    for (int i = 0; i < THM_W; i++) begin
      bk_d[i] = 32'(i) < 32'(code_d);
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge CLKIN or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= IDLE;
      code_q  <= '0;
      tgt_q   <= '0;
      bk_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tgt_q   <= tgt_d;
      bk_q    <= bk_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bk   = bk_q;
  assign code = code_q;
  assign busy = (state_q == SLEW);
  assign ovr  = ovr_q;

endmodule
